defuzzificador_it2: RTL
=======================

Name: defuzzificador_it2

Overview:
- Back end of the interval type-2 fuzzy processor: the output-side counterpart of the FOU fuzzification stage.
- Receives fired rules serially from the inference stage. Each rule carries an upper firing strength, a lower firing strength and a consequent centroid.
- Performs Nie-Tan type reduction plus defuzzification: y = Σ((UP+LOW)·C) / Σ(UP+LOW).
- Uses a sequential restoring divider and delivers one 8-bit crisp output per rule set.

Parameters:
- MAX_REGRAS, 16, maximum rules per set; accumulator widths are sized for this value.
- SAIDA_PADRAO, 8'd128, output value when the total firing weight is zero.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- Rule_Valid  input  1  rule beat present.
- Rule_Ready  output  1  block can accept a rule beat.
- Rule_UP  input  8  upper firing strength.
- Rule_LOW  input  8  lower firing strength.
- Rule_Centro  input  8  consequent centroid.
- Rule_Last  input  1  marks the final rule of the set.
- Saida  output  8  crisp output, held until the next result.
- Saida_Valid  output  1  one-cycle pulse when Saida is updated.
- Erro  output  1  status of the last result: zero total weight, or rule-count overflow.
- Busy  output  1  high in DIVIDE and DONE.

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-division):
  - state=IDLE; accumulators, rule counter and iteration counter = 0.
  - Saida=0, Saida_Valid=0, Erro=0.
- States: IDLE, ACCUM, DIVIDE, DONE.
- Rule_Ready = 1 in IDLE and ACCUM, 0 in DIVIDE and DONE.
- Beat accepted on an edge where Rule_Valid && Rule_Ready. Rule_Valid while Ready=0 is ignored; no buffering.
- Per accepted beat:
  - w = Rule_UP + Rule_LOW (9 bits, 0..510).
  - NUM += w·Rule_Centro. NUM is 21 bits; its maximum is 510·255·16 = 2,080,800.
  - DEN += w. DEN is 13 bits; its maximum is 8160.
  - Rule counter increments.
- Rule count overflow: on the first accepted beat in IDLE, the accumulators load directly (no stale add). Beats beyond MAX_REGRAS are accepted but not accumulated, and set an internal overflow flag.
- Transitions:
  - IDLE→ACCUM on accept without Last.
  - IDLE or ACCUM→DIVIDE on accept with Last (edge E0). The final beat is included in NUM/DEN. The iteration counter is loaded with 7.
  - DIVIDE: one restoring step per edge, E1..E8. At step i (7 down to 0): if REM ≥ (DEN<<i), then REM −= DEN<<i and Q[i]=1; otherwise Q[i]=0.
  - REM starts as NUM. An 8-bit quotient suffices because NUM ≤ 255·DEN. The result is truncated, not rounded.
  - At E8 (counter==0): state→DONE, Saida_Valid=1.
    - Saida = Q if DEN≠0, else SAIDA_PADRAO.
    - Erro = (DEN==0) | overflow.
  - DONE→IDLE at E9: Saida_Valid=0, accumulators and counters cleared. Saida and Erro are held.
- Latency: Saida_Valid is high in the 8th cycle after the accepting edge of the Last beat. It is independent of data, and also applies when DEN==0.
- Zero-weight case: still takes the full 8 division cycles (uniform latency).
- Rule_Last on the very first beat (single-rule set) is legal.
- Back-to-back sets: a new set can be accepted from the cycle after DONE. Minimum throughput is one set per (rules + 9) cycles.
- Reset during ACCUM or DIVIDE aborts the set: no Saida_Valid, and Saida returns to 0.

Test Plan:
- Single rule UP=200, LOW=100, C=128, Last=1 → 8 cycles later Saida=128, Saida_Valid pulses once, Erro=0.
- Two rules (255,255,C=0) then (255,255,C=200, Last) → Saida=100, Erro=0. Also check the full-scale path: 16 rules all (255,255,C=255) → Saida=255, no accumulator overflow.
- Rules (100,50,C=50) then (60,20,C=150, Last) → NUM=19500, DEN=230, Saida=84 (truncated from 84.78).
- Rules (0,0,C=77) then (0,0,C=200, Last) → Saida=128 (SAIDA_PADRAO), Erro=1, latency still 8 cycles. Next set (10,10,C=40, Last) → Saida=40, Erro=0.
- 17 rules each (10,10,C=60), Last on the 17th → Saida=60, Erro=1. Separately: hold Rule_Valid=1 during DIVIDE/DONE → Rule_Ready=0, beats are not counted, result is unchanged.
- Assert RESET at the 4th DIVIDE cycle → no Saida_Valid, Saida=0, state IDLE. A following set (40,40,C=90, Last) → Saida=90 after 8 cycles.

Source files
------------

// File: rtl/defuzzificador_it2_if.sv
// Rule beat input and crisp result output of the IT2 defuzzifier.
// Latency: n/a (wiring only).
// Backpressure: Rule_Ready gates Rule_Valid; results are not backpressured.
interface defuzzificador_it2_if;
  logic       Rule_Valid;
  logic       Rule_Ready;
  logic [7:0] Rule_UP;
  logic [7:0] Rule_LOW;
  logic [7:0] Rule_Centro;
  logic       Rule_Last;
  logic [7:0] Saida;
  logic       Saida_Valid;
  logic       Erro;
  logic       Busy;

  // rule source / result sink side
  modport master (
    output Rule_Valid, Rule_UP, Rule_LOW, Rule_Centro, Rule_Last,
    input  Rule_Ready, Saida, Saida_Valid, Erro, Busy
  );

  // defuzzifier side
  modport slave (
    input  Rule_Valid, Rule_UP, Rule_LOW, Rule_Centro, Rule_Last,
    output Rule_Ready, Saida, Saida_Valid, Erro, Busy
  );
endinterface

// File: rtl/defuzzificador_it2.sv
// Nie-Tan type reduction + defuzzification: y = sum((UP+LOW)*C) / sum(UP+LOW).
// Latency: Saida_Valid 8 cycles after the edge accepting the Last beat.
// Backpressure: Rule_Ready low while dividing and in DONE; beats offered then are dropped.
module defuzzificador_it2 #(
  parameter int         MAX_REGRAS   = 16,
  parameter logic [7:0] SAIDA_PADRAO = 8'd128
) (
  input logic                 CLK,
  input logic                 RESET,
  defuzzificador_it2_if.slave bus
);
  localparam int LOG_R = (MAX_REGRAS > 1) ? $clog2(MAX_REGRAS) : 1;
  localparam int NUM_W = 17 + LOG_R;                // 510*255*MAX_REGRAS
  localparam int DEN_W = 9 + LOG_R;                 // 510*MAX_REGRAS
  localparam int CNT_W = $clog2(MAX_REGRAS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t             state, state_nx;
  logic [NUM_W-1:0]   num, num_nx, rem, rem_nx, den_sh;
  logic [DEN_W-1:0]   den, den_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               ovf, ovf_nx;
  logic [2:0]         iter;
  logic [7:0]         quo;
  logic [7:0]         saida_r;
  logic               saida_vld_r, erro_r;
  logic [8:0]         w;
  logic [16:0]        prod;
  logic               accept, q_bit;

  assign accept = bus.Rule_Valid && bus.Rule_Ready;

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state and handshake/status outputs
  always_comb begin
    state_nx       = state;
    bus.Rule_Ready = 1'b0;
    bus.Busy       = 1'b0;
    case (state)
      IDLE: begin
        bus.Rule_Ready = 1'b1;
        if (accept) state_nx = bus.Rule_Last ? DIVIDE : ACCUM;
      end
      ACCUM: begin
        bus.Rule_Ready = 1'b1;
        if (accept && bus.Rule_Last) state_nx = DIVIDE;
      end
      DIVIDE: begin
        bus.Busy = 1'b1;
        if (iter == 3'd0) state_nx = DONE;
      end
      DONE: begin
        bus.Busy = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // accumulator update for an accepted beat; the first beat of a set loads directly
  always_comb begin
    w      = {1'b0, bus.Rule_UP} + {1'b0, bus.Rule_LOW};
    prod   = 17'(w) * 17'(bus.Rule_Centro);
    num_nx = num;
    den_nx = den;
    cnt_nx = cnt;
    ovf_nx = ovf;
    if (state == IDLE) begin
      num_nx = NUM_W'(prod);
      den_nx = DEN_W'(w);
      cnt_nx = CNT_W'(1);
      ovf_nx = 1'b0;
    end else if (cnt < CNT_W'(MAX_REGRAS)) begin
      num_nx = num + NUM_W'(prod);
      den_nx = den + DEN_W'(w);
      cnt_nx = cnt + CNT_W'(1);
    end else begin
      ovf_nx = 1'b1;                                // extra beats are swallowed, not summed
    end
  end

  // one restoring-division step: compare remainder against DEN shifted to the current bit
  always_comb begin
    den_sh = NUM_W'(den) << iter;
    q_bit  = (rem >= den_sh);
    rem_nx = q_bit ? (rem - den_sh) : rem;
  end

  // datapath: accumulate, divide, publish result, then clear for the next set
  always_ff @(posedge CLK) begin
    if (RESET) begin
      num <= '0; den <= '0; cnt <= '0; ovf <= 1'b0;
      rem <= '0; quo <= '0; iter <= '0;
      saida_r <= '0; saida_vld_r <= 1'b0; erro_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          saida_vld_r <= 1'b0;
          if (accept) begin
            num <= num_nx; den <= den_nx; cnt <= cnt_nx; ovf <= ovf_nx;
            if (bus.Rule_Last) begin
              rem  <= num_nx;
              quo  <= '0;
              iter <= 3'd7;
            end
          end
        end
        DIVIDE: begin
          rem  <= rem_nx;
          quo  <= {quo[6:0], q_bit};
          iter <= iter - 3'd1;
          if (iter == 3'd0) begin
            saida_vld_r <= 1'b1;
            saida_r     <= (den != '0) ? {quo[6:0], q_bit} : SAIDA_PADRAO;
            erro_r      <= (den == '0) | ovf;
          end
        end
        DONE: begin
          saida_vld_r <= 1'b0;
          num <= '0; den <= '0; cnt <= '0; ovf <= 1'b0;
          rem <= '0; quo <= '0; iter <= '0;
        end
        default: saida_vld_r <= 1'b0;
      endcase
    end
  end

  assign bus.Saida       = saida_r;
  assign bus.Saida_Valid = saida_vld_r;
  assign bus.Erro        = erro_r;
endmodule
